// File: rtl/mdu_pipe.sv
// Multiply/divide unit with a latency counter and HI/LO result registers.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (op codes 7/8).
module mdu_pipe #(
  parameter int DATA_W   = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              E_MDStart,
  input  logic [3:0]        E_MDOp,
  input  logic [DATA_W-1:0] E_RS,
  input  logic [DATA_W-1:0] E_RT,
  output logic              E_Busy,
  output logic              E_Stall,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int W2 = 2 * DATA_W;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  logic [3:0]        cnt;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;

  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;
  logic madd_ok;

`ifdef MDU_MADD_EN
  assign madd_ok = 1'b1;
`else
  assign madd_ok = 1'b0;
`endif

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      (E_MDOp == OP_MULT),
      (E_MDOp == OP_MULTU): is_mul = 1'b1;
      (E_MDOp == OP_DIV),
      (E_MDOp == OP_DIVU):  is_div = 1'b1;
      (E_MDOp == OP_MTHI):  is_mthi = 1'b1;
      (E_MDOp == OP_MTLO):  is_mtlo = 1'b1;
      (E_MDOp == OP_MADD),
      (E_MDOp == OP_MADDU): is_mul = madd_ok;
      default: ;
    endcase
  end

  assign E_Busy  = (cnt != 4'd0);
  assign E_Stall = E_Busy | (E_MDStart & (is_mul | is_div));

  logic          sgn;
  logic          acc;
  logic [W2-1:0] prod;
  logic [W2-1:0] mul_s;
  logic [W2-1:0] mul_u;

  assign sgn = (op_q == OP_MULT) | (op_q == OP_DIV) |
               (op_q == OP_MADD);
  assign acc = (op_q == OP_MADD) | (op_q == OP_MADDU);

  assign mul_s = {{DATA_W{rs_q[DATA_W-1]}}, rs_q} *
                 {{DATA_W{rt_q[DATA_W-1]}}, rt_q};
  assign mul_u = {{DATA_W{1'b0}}, rs_q} *
                 {{DATA_W{1'b0}}, rt_q};
  assign prod  = sgn ? mul_s : mul_u;

  // Signed divide works on magnitudes; MIN/-1 wraps back to MIN with rem 0.
  logic              neg_a;
  logic              neg_b;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] uq;
  logic [DATA_W-1:0] ur;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  assign neg_a = sgn & rs_q[DATA_W-1];
  assign neg_b = sgn & rt_q[DATA_W-1];
  assign mag_a = neg_a ? -rs_q : rs_q;
  assign mag_b = neg_b ? -rt_q : rt_q;
  assign uq    = mag_a / mag_b;
  assign ur    = mag_a % mag_b;
  assign quo   = (neg_a ^ neg_b) ? -uq : uq;
  assign rem   = neg_a ? -ur : ur;

  logic done_mul;
  logic done_div;

  assign done_mul = (op_q == OP_MULT) | (op_q == OP_MULTU) | acc;
  assign done_div = (op_q == OP_DIV) | (op_q == OP_DIVU);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      op_q <= 4'd0;
      rs_q <= '0;
      rt_q <= '0;
      HI   <= '0;
      LO   <= '0;
    end else if (E_Busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        if (done_mul) begin
          if (acc) {HI, LO} <= {HI, LO} + prod;
          else     {HI, LO} <= prod;
        end else if (done_div && rt_q != '0) begin
          LO <= quo;
          HI <= rem;
        end
      end
    end else if (E_MDStart) begin
      if (is_mul | is_div) begin
        op_q <= E_MDOp;
        rs_q <= E_RS;
        rt_q <= E_RT;
        cnt  <= is_mul ? 4'(MULT_LAT) : 4'(DIV_LAT);
      end
      if (is_mthi) HI <= E_RS;
      if (is_mtlo) LO <= E_RS;
    end
  end

endmodule
